// File: rtl/text_vram_pkg.sv
// -----------------------------------------------------------------------------
// text_vram_pkg
// Shared definitions for the text console video RAM:
//   - default geometry (COLS x ROWS cells of DATA_W bits)
//   - fill engine state encoding
//   - map_cell(): logical (row, col, scroll) -> linear cell address, including
//     scroll wrap-around and the range check. Out-of-range coordinates return
//     MAP_NONE, which is never a valid cell address.
// -----------------------------------------------------------------------------
package text_vram_pkg;

    localparam int DEF_COLS   = 80;
    localparam int DEF_ROWS   = 30;
    localparam int DEF_DATA_W = 16;

    // Sentinel returned by map_cell for coordinates outside the screen.
    localparam logic [31:0] MAP_NONE = 32'hFFFF_FFFF;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_e;

    // Map a logical screen coordinate to a linear cell address.
    // A scroll value outside the screen is treated as no scroll; the scrolled
    // row wraps back to the top with a single conditional subtract, which is
    // enough because both operands are already below rows.
    function automatic logic [31:0] map_cell(
        input logic [31:0] row,
        input logic [31:0] col,
        input logic [31:0] scroll,
        input logic [31:0] cols,
        input logic [31:0] rows
    );
        logic [31:0] scroll_eff;
        logic [31:0] phys_row;
        scroll_eff = (scroll >= rows) ? 32'd0 : scroll;
        phys_row   = row + scroll_eff;
        if ((row >= rows) || (col >= cols)) begin
            map_cell = MAP_NONE;
        end else begin
            if (phys_row >= rows) begin
                phys_row = phys_row - rows;
            end else begin
                phys_row = phys_row;
            end
            map_cell = (phys_row * cols) + col;
        end
    endfunction

endpackage

// File: rtl/text_vram_fill.sv
// -----------------------------------------------------------------------------
// text_vram_fill
// Hardware screen fill engine. On fill_start (while idle) it latches
// fill_value and writes it to every cell, one cell per cycle, from address 0
// up to DEPTH-1, then returns to idle. fill_start during a fill is ignored.
//
// Ports:
//   sys_clk     in   clock, rising edge
//   sys_rst     in   asynchronous active-high reset
//   fill_start  in   start request (pulse)
//   fill_value  in   fill pattern, sampled with fill_start
//   busy        out  fill in progress
//   fill_we     out  write request to the RAM write mux (has priority)
//   fill_addr   out  cell address for the write request
//   fill_data   out  data for the write request
// -----------------------------------------------------------------------------
module text_vram_fill
    import text_vram_pkg::*;
#(
    parameter int DEPTH  = DEF_COLS * DEF_ROWS,
    parameter int ADDR_W = $clog2(DEF_COLS * DEF_ROWS),
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              fill_start,
    input  logic [DATA_W-1:0] fill_value,
    output logic              busy,
    output logic              fill_we,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [DATA_W-1:0] fill_data
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    fill_state_e       state_r;
    fill_state_e       state_nx_s;
    logic [ADDR_W-1:0] count_r;
    logic [ADDR_W-1:0] count_nx_s;
    logic [DATA_W-1:0] value_r;
    logic [DATA_W-1:0] value_nx_s;

    // State, cell counter and latched pattern registers.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_r <= IDLE;
            count_r <= '0;
            value_r <= '0;
        end else begin
            state_r <= state_nx_s;
            count_r <= count_nx_s;
            value_r <= value_nx_s;
        end
    end

    // Next-state logic and write request generation.
    always_comb begin
        state_nx_s = state_r;
        count_nx_s = count_r;
        value_nx_s = value_r;
        fill_we    = 1'b0;
        case (state_r)
            IDLE: begin
                if (fill_start) begin
                    state_nx_s = FILL;
                    count_nx_s = '0;
                    value_nx_s = fill_value;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            FILL: begin
                fill_we = 1'b1;
                if (count_r == LAST_ADDR) begin
                    state_nx_s = IDLE;
                    count_nx_s = '0;
                end else begin
                    count_nx_s = count_r + ADDR_W'(1);
                end
            end
            default: begin
                state_nx_s = IDLE;
                count_nx_s = '0;
            end
        endcase
    end

    assign busy      = (state_r == FILL);
    assign fill_addr = count_r;
    assign fill_data = value_r;

endmodule

// File: rtl/text_vram.sv
// -----------------------------------------------------------------------------
// text_vram
// COLS x ROWS character/attribute video RAM shared by the CPU and the text
// renderer. One write port (fill engine or CPU, fill wins) and two read
// ports (CPU read, video read). The cell array itself is never reset.
//
// Ports:
//   sys_clk, sys_rst      clock / asynchronous active-high reset
//   sys_addr              linear CPU cell address (row*COLS+col)
//   sys_wdata, sys_wren   CPU write data and bytewise enables
//   sys_rden              CPU read request
//   sys_rdata, sys_rvalid CPU read data, one cycle after the request
//   fill_start, fill_value, busy   screen fill engine control/status
//   scroll_row            physical row shown at logical row 0
//   video_re, video_col, video_row  renderer read request (logical coords)
//   video_data, video_valid         renderer read data, two cycles later
// -----------------------------------------------------------------------------
module text_vram
    import text_vram_pkg::*;
#(
    parameter  int COLS   = DEF_COLS,
    parameter  int ROWS   = DEF_ROWS,
    parameter  int DATA_W = DEF_DATA_W,
    localparam int DEPTH  = COLS * ROWS,
    localparam int ADDR_W = $clog2(DEPTH),
    localparam int COL_W  = $clog2(COLS),
    localparam int ROW_W  = $clog2(ROWS)
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic [ADDR_W-1:0]   sys_addr,
    input  logic [DATA_W-1:0]   sys_wdata,
    input  logic [DATA_W/8-1:0] sys_wren,
    input  logic                sys_rden,
    output logic [DATA_W-1:0]   sys_rdata,
    output logic                sys_rvalid,
    input  logic                fill_start,
    input  logic [DATA_W-1:0]   fill_value,
    output logic                busy,
    input  logic [ROW_W-1:0]    scroll_row,
    input  logic                video_re,
    input  logic [COL_W-1:0]    video_col,
    input  logic [ROW_W-1:0]    video_row,
    output logic [DATA_W-1:0]   video_data,
    output logic                video_valid
);

    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] mem_r [DEPTH];

    logic              fill_we_s;
    logic [ADDR_W-1:0] fill_addr_s;
    logic [DATA_W-1:0] fill_data_s;

    logic              wr_en_s;
    logic [ADDR_W-1:0] wr_addr_s;
    logic [DATA_W-1:0] wr_data_s;
    logic [NB-1:0]     wr_be_s;

    logic              sys_in_range_s;
    logic [31:0]       vid_map_s;
    logic              vid_ok_s;
    logic [ADDR_W-1:0] vid_addr_s;

    logic              v1_valid_r;
    logic              v1_ok_r;
    logic [ADDR_W-1:0] v1_addr_r;

    text_vram_fill #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fill (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .fill_start (fill_start),
        .fill_value (fill_value),
        .busy       (busy),
        .fill_we    (fill_we_s),
        .fill_addr  (fill_addr_s),
        .fill_data  (fill_data_s)
    );

    assign sys_in_range_s = (32'(sys_addr) < 32'(DEPTH));

    // The sentinel from map_cell is above DEPTH, so one compare covers both
    // the column/row range check and the address itself.
    assign vid_map_s  = map_cell(32'(video_row), 32'(video_col), 32'(scroll_row),
                                 32'(COLS), 32'(ROWS));
    assign vid_ok_s   = (vid_map_s < 32'(DEPTH));
    assign vid_addr_s = vid_map_s[ADDR_W-1:0];

    // Write port mux: fill engine first; CPU writes only when idle and in range.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_addr_s = '0;
        wr_data_s = '0;
        wr_be_s   = '0;
        if (fill_we_s) begin
            wr_en_s   = 1'b1;
            wr_addr_s = fill_addr_s;
            wr_data_s = fill_data_s;
            wr_be_s   = '1;
        end else if (!busy && sys_in_range_s && (sys_wren != '0)) begin
            wr_en_s   = 1'b1;
            wr_addr_s = sys_addr;
            wr_data_s = sys_wdata;
            wr_be_s   = sys_wren;
        end else begin
            wr_en_s   = 1'b0;
        end
    end

    // Cell array write, bytewise; no reset so it maps onto block RAM.
    always_ff @(posedge sys_clk) begin
        if (wr_en_s) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_be_s[i]) begin
                    mem_r[wr_addr_s][i*8 +: 8] <= wr_data_s[i*8 +: 8];
                end
            end
        end
    end

    // CPU read port: one registered stage, old data on same-cycle write.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sys_rdata  <= '0;
            sys_rvalid <= 1'b0;
        end else begin
            sys_rvalid <= sys_rden;
            if (sys_rden) begin
                sys_rdata <= sys_in_range_s ? mem_r[sys_addr] : '0;
            end
        end
    end

    // Video stage 1: register the scrolled cell address and its range flag.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            v1_valid_r <= 1'b0;
            v1_ok_r    <= 1'b0;
            v1_addr_r  <= '0;
        end else begin
            v1_valid_r <= video_re;
            if (video_re) begin
                v1_ok_r   <= vid_ok_s;
                v1_addr_r <= vid_addr_s;
            end
        end
    end

    // Video stage 2: RAM read; out-of-screen requests still return valid zero.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            video_data  <= '0;
            video_valid <= 1'b0;
        end else begin
            video_valid <= v1_valid_r;
            if (v1_valid_r) begin
                video_data <= v1_ok_r ? mem_r[v1_addr_r] : '0;
            end
        end
    end

endmodule

// File: tb/tb_text_vram.sv
// -----------------------------------------------------------------------------
// tb_text_vram
// Directed bench for text_vram (80 x 30 x 16). Read expectations are queued
// with the cycle they are due when a request is driven; every cycle the
// outputs are checked against the queue heads (and valids must be low when
// nothing is due).
// -----------------------------------------------------------------------------
module tb_text_vram;

    localparam int COLS   = 80;
    localparam int ROWS   = 30;
    localparam int DATA_W = 16;
    localparam int DEPTH  = COLS * ROWS;
    localparam int ADDR_W = 12;
    localparam int COL_W  = 7;
    localparam int ROW_W  = 5;

    typedef struct {
        int          due;
        logic [15:0] data;
    } exp_t;

    logic              sys_clk = 1'b0;
    logic              sys_rst;
    logic [ADDR_W-1:0] sys_addr;
    logic [DATA_W-1:0] sys_wdata;
    logic [1:0]        sys_wren;
    logic              sys_rden;
    logic [DATA_W-1:0] sys_rdata;
    logic              sys_rvalid;
    logic              fill_start;
    logic [DATA_W-1:0] fill_value;
    logic              busy;
    logic [ROW_W-1:0]  scroll_row;
    logic              video_re;
    logic [COL_W-1:0]  video_col;
    logic [ROW_W-1:0]  video_row;
    logic [DATA_W-1:0] video_data;
    logic              video_valid;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    exp_t        sq[$];
    exp_t        vq[$];
    logic [15:0] model [DEPTH];

    always #5 sys_clk = ~sys_clk;

    text_vram #(
        .COLS   (COLS),
        .ROWS   (ROWS),
        .DATA_W (DATA_W)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .sys_addr    (sys_addr),
        .sys_wdata   (sys_wdata),
        .sys_wren    (sys_wren),
        .sys_rden    (sys_rden),
        .sys_rdata   (sys_rdata),
        .sys_rvalid  (sys_rvalid),
        .fill_start  (fill_start),
        .fill_value  (fill_value),
        .busy        (busy),
        .scroll_row  (scroll_row),
        .video_re    (video_re),
        .video_col   (video_col),
        .video_row   (video_row),
        .video_data  (video_data),
        .video_valid (video_valid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference video lookup: modulo wrap on the logical row.
    function automatic logic [15:0] ref_vid(input int row, input int col, input int scroll);
        int s;
        if (row >= ROWS || col >= COLS) return 16'h0000;
        s = (scroll >= ROWS) ? 0 : scroll;
        return model[((row + s) % ROWS) * COLS + col];
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        #1;
        cyc++;
        if (sq.size() > 0 && sq[0].due == cyc) begin
            chk("sys_rvalid", 32'(sys_rvalid), 32'd1);
            chk("sys_rdata", 32'(sys_rdata), 32'(sq[0].data));
            void'(sq.pop_front());
        end else begin
            chk("sys_rvalid_idle", 32'(sys_rvalid), 32'd0);
        end
        if (vq.size() > 0 && vq[0].due == cyc) begin
            chk("video_valid", 32'(video_valid), 32'd1);
            chk("video_data", 32'(video_data), 32'(vq[0].data));
            void'(vq.pop_front());
        end else begin
            chk("video_valid_idle", 32'(video_valid), 32'd0);
        end
    endtask

    task automatic idle();
        sys_wren   = 2'b00;
        sys_rden   = 1'b0;
        video_re   = 1'b0;
        fill_start = 1'b0;
    endtask

    task automatic drv_write(input int a, input logic [15:0] d, input logic [1:0] be);
        sys_addr  = ADDR_W'(a);
        sys_wdata = d;
        sys_wren  = be;
    endtask

    task automatic mwrite(input int a, input logic [15:0] d, input logic [1:0] be);
        if (be[0]) model[a][7:0]  = d[7:0];
        if (be[1]) model[a][15:8] = d[15:8];
    endtask

    task automatic drv_read(input int a);
        logic [15:0] e;
        e = 16'h0000;
        if (a < DEPTH) e = model[a];
        sys_addr = ADDR_W'(a);
        sys_rden = 1'b1;
        sq.push_back('{cyc + 1, e});
    endtask

    task automatic drv_vid(input int row, input int col, input int scroll);
        video_row  = ROW_W'(row);
        video_col  = COL_W'(col);
        scroll_row = ROW_W'(scroll);
        video_re   = 1'b1;
        vq.push_back('{cyc + 2, ref_vid(row, col, scroll)});
    endtask

    initial begin
        int cnt;
        sys_rst = 1'b1;
        idle();
        sys_addr = '0; sys_wdata = '0; fill_value = '0;
        scroll_row = '0; video_col = '0; video_row = '0;

        // Reset state
        tick();
        tick();
        chk("rst_sys_rdata", 32'(sys_rdata), 32'd0);
        chk("rst_video_data", 32'(video_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        sys_rst = 1'b0;
        tick();

        // Bytewise write then read back
        drv_write(5, 16'hABCD, 2'b11); tick(); mwrite(5, 16'hABCD, 2'b11);
        drv_write(5, 16'h00EE, 2'b01); tick(); mwrite(5, 16'h00EE, 2'b01);
        idle();
        chk("model_abee", 32'(model[5]), 32'h0000ABEE);
        drv_read(5); tick(); idle();
        tick();

        // Scroll wrap, back-to-back video reads
        drv_write(29 * COLS + 3, 16'h1111, 2'b11); tick(); mwrite(29 * COLS + 3, 16'h1111, 2'b11);
        drv_write(3, 16'h2222, 2'b11); tick(); mwrite(3, 16'h2222, 2'b11);
        idle();
        drv_vid(0, 3, 29); tick();
        drv_vid(1, 3, 29); tick();
        drv_vid(0, 3, 31); tick();
        drv_vid(0, 90, 0); tick();
        drv_vid(31, 3, 0); tick();
        drv_vid(29, 3, 0); tick();
        idle(); tick(); tick();

        // Out-of-range CPU write and reads
        drv_write(2400, 16'h7777, 2'b11); tick(); idle();
        drv_read(2400); tick();
        drv_read(4000); tick();
        drv_read(5); tick();
        idle(); tick();

        // Collision: video read stage and CPU read both meet the write edge
        drv_write(7, 16'h1234, 2'b11); tick(); mwrite(7, 16'h1234, 2'b11); idle();
        drv_vid(0, 7, 0); tick();
        video_re = 1'b0;
        drv_write(7, 16'h5555, 2'b11);
        drv_read(7);
        tick(); mwrite(7, 16'h5555, 2'b11);
        idle();
        drv_read(7);
        drv_vid(0, 7, 0);
        tick(); idle();
        // A write is visible to a video request sampled on the same edge
        drv_write(8, 16'hAAAA, 2'b11); mwrite(8, 16'hAAAA, 2'b11);
        drv_vid(0, 8, 0);
        tick(); idle(); tick(); tick();

        // Full fill with dropped CPU writes and an ignored restart
        fill_value = 16'h0720; fill_start = 1'b1;
        tick();
        fill_start = 1'b0; fill_value = 16'h0000;
        cnt = 0;
        while (busy === 1'b1 && cnt < 3000) begin
            cnt++;
            if (cnt == 5) drv_write(10, 16'h9999, 2'b11);
            if (cnt == 7) drv_write(2, 16'h8888, 2'b11);
            if (cnt == 6 || cnt == 8) sys_wren = 2'b00;
            if (cnt == 10) begin fill_start = 1'b1; fill_value = 16'hDEAD; end
            if (cnt == 11) begin fill_start = 1'b0; fill_value = 16'h0000; end
            tick();
        end
        chk("fill_busy_cycles", 32'(cnt), 32'd2400);
        for (int i = 0; i < DEPTH; i++) model[i] = 16'h0720;
        drv_read(0); tick();
        drv_read(10); tick();
        drv_read(2); tick();
        drv_read(2399); tick();
        idle();
        drv_vid(29, 79, 7); tick();
        idle(); tick(); tick();

        // Reset in the middle of a fill
        fill_value = 16'h1F41; fill_start = 1'b1;
        tick();
        fill_start = 1'b0; fill_value = 16'h0000;
        for (int i = 1; i <= 98; i++) tick();
        for (int i = 0; i <= 98; i++) model[i] = 16'h1F41;
        drv_read(50);
        drv_vid(0, 50, 0);
        tick(); idle();
        sys_rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_sys_rvalid", 32'(sys_rvalid), 32'd0);
        chk("midrst_video_valid", 32'(video_valid), 32'd0);
        chk("midrst_sys_rdata", 32'(sys_rdata), 32'd0);
        sq.delete();
        vq.delete();
        tick();
        sys_rst = 1'b0;
        tick();
        tick();
        chk("postrst_busy", 32'(busy), 32'd0);
        drv_read(50); tick();
        drv_read(2000); tick();
        idle();
        drv_write(60, 16'hBEEF, 2'b11); tick(); mwrite(60, 16'hBEEF, 2'b11); idle();
        drv_read(60); tick(); idle();
        tick(); tick();

        chk("sb_sys_drained", 32'(sq.size()), 32'd0);
        chk("sb_vid_drained", 32'(vq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/text_vram.md
# text_vram

Parametrised single-clock character/attribute video RAM for the text console. It sits between the CPU bus (sys port) and the text renderer (video port). It provides a COLS x ROWS buffer of DATA_W-bit cells with bytewise writes and registered CPU reads. A pipelined row/column video read port applies hardware scroll with wrap-around. A hardware fill engine clears or fills the whole screen.

## Interface
- COLS, 80, characters per row (>=2)
- ROWS, 30, rows per screen (>=2)
- DATA_W, 16, cell width (char byte + attribute byte); multiple of 8
- DEPTH, COLS*ROWS (derived), number of cells
- ADDR_W, clog2(DEPTH) (derived); COL_W = clog2(COLS), ROW_W = clog2(ROWS)

Ports:
- sys_clk  in  1  single clock, rising edge
- sys_rst  in  1  reset, asynchronous, active-high
- sys_addr  in  ADDR_W  linear cell address (row*COLS+col)
- sys_wdata  in  DATA_W  write data
- sys_wren  in  DATA_W/8  bytewise write enables; bit i writes byte i
- sys_rden  in  1  read request
- sys_rdata  out  DATA_W  read data
- sys_rvalid  out  1  sys_rdata valid, one-cycle pulse
- fill_start  in  1  start fill (pulse)
- fill_value  in  DATA_W  fill pattern, sampled with fill_start
- busy  out  1  fill in progress
- scroll_row  in  ROW_W  physical row displayed at logical row 0
- video_re  in  1  video read request
- video_col  in  COL_W  logical column
- video_row  in  ROW_W  logical row
- video_data  out  DATA_W  cell data
- video_valid  out  1  video_data valid

## Operation
- Storage is 1 write / 2 read ports and is not reset. Contents are undefined after power-up until written or filled.
- **Sys write:** each byte i with sys_wren[i]=1 is written. Writes with sys_addr >= DEPTH are ignored. While busy=1, all sys writes are dropped.
- **Sys read:** sys_rden=1 returns the cell at sys_addr. An out-of-range address returns 0. Reads are allowed while busy and return current contents.
- **Video read:**
  - phys_row = video_row + scroll_row; subtract ROWS if the sum >= ROWS.
  - scroll_row >= ROWS is treated as 0.
  - Address = phys_row*COLS + video_col.
  - video_col >= COLS or video_row >= ROWS returns 0, with video_valid still asserted.
- **Fill FSM (IDLE, FILL):**
  - IDLE -> FILL on fill_start. Latches fill_value and clears the word counter.
  - In FILL, writes the latched value to the cell at the counter each cycle and increments it.
  - After writing DEPTH-1, returns to IDLE.
  - fill_start while in FILL is ignored.
- **Collisions:** read-during-write to the same cell on either port returns the old data.
- **Reset mid-fill:** FSM returns to IDLE and busy=0. Memory is left partially filled.

## Timing
- Reset values: sys_rdata=0, sys_rvalid=0, video_data=0, video_valid=0, busy=0, FSM=IDLE, and all pipeline valids are 0.
- **Sys read latency is 1 cycle.** A request at edge N gives sys_rdata/sys_rvalid after edge N+1.
- **Video read latency is 2 cycles:**
  - Stage 1 registers the address, scroll_row being sampled at the request edge.
  - Stage 2 performs the RAM read.
  - Full throughput, one request per cycle; video_valid follows video_re delayed by 2.
- **Fill timing (fill_start sampled at edge N):**
  - busy=1 from after edge N.
  - Cell k is written at edge N+1+k.
  - busy=0 after edge N+DEPTH.
  - A sys write at edge N is still performed; sys writes from N+1 through N+DEPTH are dropped.
- A write at edge M is visible to a sys read issued at edge M+1. It is visible to a video request issued at edge M.

## Structure
- **text_vram_pkg** holds:
  - default COLS/ROWS/DATA_W;
  - the fill state enum {IDLE, FILL};
  - a function mapping (row, col, scroll) to a linear address, including the wrap and range check.
- **Sub-module text_vram_fill** holds the fill FSM, counter, latched value and busy output. It presents a write request/address/data to the top-level write mux, which gives the fill engine priority and gates sys writes.

## Test plan
- **Bytewise write (COLS=80, ROWS=30):** write 0xABCD to addr 5 with wren=2'b11, then 0x00EE with wren=2'b01, then read addr 5 -> sys_rdata=0xABEE after 1 cycle, sys_rvalid pulse.
- **Scroll wrap:** cells (row 29, col 3)=0x1111 and (row 0, col 3)=0x2222; scroll_row=29 with video read (row 0, col 3) -> 0x1111; video read (row 1, col 3) -> 0x2222; both 2 cycles after request, back-to-back valid.
- **Fill:** fill_start with value 0x0720 at edge N -> busy high for exactly 2400 cycles. A sys write to addr 10 at N+5 is dropped. After busy falls, reads of addr 0, 10, 2399 all return 0x0720.
- **Reset mid-fill:** assert sys_rst at N+100 of a fill -> busy=0 immediately and all valids 0. After release, addr 50 holds the fill value; a subsequent sys write is accepted.
- **Out-of-range:**
  - A sys write to addr 2400 leaves contents unchanged.
  - A sys read of addr 4000 returns 0.
  - A video read at col 90 returns 0 with video_valid=1.
  - scroll_row=31 behaves as scroll_row=0.
- **Collision:** write 0x5555 to addr 7 (old value 0x1234) while reading addr 7 in the same cycle on both ports -> both return 0x1234. Next read -> 0x5555.
